// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional even/odd parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the bit centre.
module uart_rx_cfg #(
  parameter int CLOCK_SPEED = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_data_in,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_break,
  output logic                 rx_busy
);

  localparam int CLK_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'((CLK_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                 state;
  logic                   sync1, line_s, h0;
  logic                   armed;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   data_sh;
  logic                   perr_sh, ferr_sh, zero_sh, last_stop;
  logic                   sample;
  logic                   tick;

  // h0 is line_s one clock late, so the decision clock sees centre-1/centre/centre+1
  // as h1/h0/line_s and both builds decide on the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      line_s <= 1'b1;
      h0     <= 1'b1;
    end else begin
      sync1  <= rx_data_in;
      line_s <= sync1;
      h0     <= line_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic h1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) h1 <= 1'b1;
    else        h1 <= h0;
  end
  assign sample = (h1 & h0) | (h1 & line_s) | (h0 & line_s);
`else
  assign sample = h0;
`endif

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      stop_idx   <= 1'b0;
      data_sh    <= '0;
      perr_sh    <= 1'b0;
      ferr_sh    <= 1'b0;
      zero_sh    <= 1'b0;
      last_stop  <= 1'b0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_break   <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          idx      <= '0;
          stop_idx <= 1'b0;
          if (line_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (!sample) begin
              state   <= DATA;
              data_sh <= '0;
              perr_sh <= 1'b0;
              ferr_sh <= 1'b0;
              zero_sh <= 1'b1;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            cnt          <= '0;
            data_sh[idx] <= sample;
            zero_sh      <= zero_sh & ~sample;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (tick) begin
            cnt     <= '0;
            perr_sh <= (PARITY_MODE == 1) ? (^data_sh ^ sample) : ~(^data_sh ^ sample);
            zero_sh <= zero_sh & ~sample;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            cnt       <= '0;
            last_stop <= sample;
            zero_sh   <= zero_sh & ~sample;
            if (!sample) ferr_sh <= 1'b1;
            if (stop_idx == STOP_LAST) begin
              stop_idx <= 1'b0;
              state    <= DONE;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // A low final stop bit disarms so a held-low line is not taken as a new start.
          rx_valid   <= 1'b1;
          rx_busy    <= 1'b0;
          rx_byte    <= data_sh;
          parity_err <= (PARITY_MODE != 0) & perr_sh;
          frame_err  <= ferr_sh;
          rx_break   <= zero_sh;
          armed      <= last_stop;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised scoreboard bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance,
// both at 10 clocks per bit.
module tb_uart_rx_cfg;

  localparam int CPB = 10;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line_a = 1'b1;
  logic line_b = 1'b1;

  logic [7:0] byte_a;
  logic       valid_a, perr_a, ferr_a, brk_a, busy_a;
  logic [6:0] byte_b;
  logic       valid_b, perr_b, ferr_b, brk_b, busy_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] exp_a[$];
  logic [11:0] exp_b[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLOCK_SPEED(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data_in(line_a), .rx_byte(byte_a), .rx_valid(valid_a),
    .parity_err(perr_a), .frame_err(ferr_a), .rx_break(brk_a), .rx_busy(busy_a)
  );

  uart_rx_cfg #(.CLOCK_SPEED(100), .BAUD_RATE(10), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data_in(line_b), .rx_byte(byte_b), .rx_valid(valid_b),
    .parity_err(perr_b), .frame_err(ferr_b), .rx_break(brk_b), .rx_busy(busy_b)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  // Monitors: pop one expectation per rx_valid pulse.
  logic prev_a = 1'b0;
  always @(negedge clk) begin
    if (rst_n && valid_a) begin
      check("a_busy_with_valid", 16'(busy_a), 16'd0);
      check("a_valid_width", 16'(prev_a), 16'd0);
      if (exp_a.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected_valid: got byte %h required no frame", byte_a);
      end else begin
        check("a_frame", 16'({brk_a, ferr_a, perr_a, 1'b0, byte_a}), 16'(exp_a.pop_front()));
      end
    end
    prev_a = valid_a;
  end

  logic prev_b = 1'b0;
  always @(negedge clk) begin
    if (rst_n && valid_b) begin
      check("b_busy_with_valid", 16'(busy_b), 16'd0);
      check("b_valid_width", 16'(prev_b), 16'd0);
      if (exp_b.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected_valid: got byte %h required no frame", byte_b);
      end else begin
        check("b_frame", 16'({brk_b, ferr_b, perr_b, 2'b00, byte_b}), 16'(exp_b.pop_front()));
      end
    end
    prev_b = valid_b;
  end

  task automatic set_line(input int which, input logic v);
    if (which == 0) line_a = v;
    else            line_b = v;
  endtask

  task automatic idle(input int n);
    line_a = 1'b1;
    line_b = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_a"}, 16'({byte_a, valid_a, perr_a, ferr_a, brk_a, busy_a}), 16'd0);
    check({tag, "_b"}, 16'({byte_b, valid_b, perr_b, ferr_b, brk_b, busy_b}), 16'd0);
  endtask

  // Builds the frame bit list, derives the expected result from it, then drives it.
  task automatic send(input int which, input logic [8:0] data, input logic par_flip,
                      input logic [1:0] stop_vals, input logic spike, input int abort_at,
                      input logic expect_it);
    int nbits;
    int pm;
    int ns;
    logic bq[$];
    logic [8:0] mask;
    logic [8:0] dm;
    logic pbit, x, perr, ferr, brk;
    nbits = (which == 0) ? 8 : 7;
    pm    = (which == 0) ? 0 : 1;
    ns    = (which == 0) ? 1 : 2;
    mask  = 9'((1 << nbits) - 1);
    dm    = data & mask;
    pbit  = 1'b0;
    ferr  = 1'b0;
    perr  = 1'b0;
    bq.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bq.push_back(dm[i]);
    if (pm != 0) begin
      pbit = ((pm == 1) ? (^dm) : ~(^dm)) ^ par_flip;
      bq.push_back(pbit);
      x    = (^dm) ^ pbit;
      perr = (pm == 1) ? x : ~x;
    end
    for (int i = 0; i < ns; i++) begin
      bq.push_back(stop_vals[i]);
      if (!stop_vals[i]) ferr = 1'b1;
    end
    brk = 1'b1;
    foreach (bq[k]) if (bq[k]) brk = 1'b0;
    if (spike && !MAJ) dm = dm ^ mask;
    if (expect_it) begin
      if (which == 0) exp_a.push_back({brk, ferr, perr, dm});
      else            exp_b.push_back({brk, ferr, perr, dm});
    end
    for (int k = 0; k < bq.size(); k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (abort_at == k && c == 3) begin
          rst_n = 1'b0;
          #1;
          check_reset_values("mid_frame_reset");
          @(negedge clk);
          rst_n = 1'b1;
          set_line(which, 1'b1);
          return;
        end
        set_line(which, bq[k] ^ (spike && k >= 1 && k <= nbits && c == 4));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int busy_cnt;
    int w;
    logic [1:0] sv;
    rst_n = 1'b0;
    #2;
    check_reset_values("reset_async");
    repeat (3) @(negedge clk);
    check_reset_values("reset_held");
    rst_n = 1'b1;
    idle(5);

    send(0, 9'h0A5, 1'b0, 2'b11, 1'b0, -1, 1'b1);
    idle(20);
    send(1, 9'h055, 1'b1, 2'b11, 1'b0, -1, 1'b1);
    idle(20);
    send(1, 9'h02A, 1'b0, 2'b01, 1'b0, -1, 1'b1);
    idle(20);

    // Break: whole frame low, then 30 more clocks low before returning high.
    send(1, 9'h000, 1'b0, 2'b00, 1'b0, -1, 1'b1);
    line_b = 1'b0;
    repeat (30) @(negedge clk);
    idle(30);

    for (int i = 0; i < 12; i++) begin
      w  = $urandom_range(0, 1);
      sv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      send(w, 9'($urandom_range(0, 511)), ($urandom_range(0, 3) == 0), sv, 1'b0, -1, 1'b1);
      idle($urandom_range(10, 30));
    end

    // Short low glitch on an idle line: start is rejected well inside one bit time.
    busy_cnt = 0;
    line_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
    end
    line_a = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
    end
    check("glitch_busy_bounded", 16'(busy_cnt > 0 && busy_cnt <= CPB), 16'd1);
    check("glitch_busy_released", 16'(busy_a), 16'd0);

    send(0, 9'h096, 1'b0, 2'b11, 1'b0, 5, 1'b0);
    idle(20);
    send(0, 9'h03C, 1'b0, 2'b11, 1'b0, -1, 1'b1);
    idle(20);

    send(0, 9'h081, 1'b0, 2'b11, 1'b1, -1, 1'b1);
    idle(20);

    for (int i = 0; i < 300 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(negedge clk);
    check("drain_a", 16'(exp_a.size()), 16'd0);
    check("drain_b", 16'(exp_b.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
